register_file_mp: RTL

//  Parametrised multi-port integer register file for the RISC-V core: two read ports, two write ports.

---
 rtl/register_file_mp_if.sv | 33 +++
 rtl/register_file_mp.sv | 121 ++++++++++++
 2 files changed

// File: rtl/register_file_mp_if.sv
// Bus bundle for the multi-port register file: decode-side read ports,
// writeback/load-return write ports and the ready flag.
interface register_file_mp_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] addr_rs1;
  logic [ADDR_W-1:0] addr_rs2;
  logic [XLEN-1:0]   data_rs1;
  logic [XLEN-1:0]   data_rs2;
  logic              we0;
  logic [ADDR_W-1:0] addr_rd0;
  logic [XLEN-1:0]   data_rd0;
  logic              we1;
  logic [ADDR_W-1:0] addr_rd1;
  logic [XLEN-1:0]   data_rd1;
  logic              ready;

  modport master (
    output rd_en, addr_rs1, addr_rs2,
    output we0, addr_rd0, data_rd0,
    output we1, addr_rd1, data_rd1,
    input  data_rs1, data_rs2, ready
  );

  modport slave (
    input  rd_en, addr_rs1, addr_rs2,
    input  we0, addr_rd0, data_rd0,
    input  we1, addr_rd1, data_rd1,
    output data_rs1, data_rs2, ready
  );
endinterface

// File: rtl/register_file_mp.sv
// Two-read/two-write integer register file with registered, stallable reads,
// optional write-to-read bypass and a post-reset clear sequencer.
module register_file_mp #(
  parameter int          XLEN      = 32,
  parameter int          NUM_REGS  = 32,
  parameter int          ADDR_W    = $clog2(NUM_REGS),
  parameter int          SP_INDEX  = 2,
  parameter logic [31:0] SP_INIT   = 32'h0100_0000,
  parameter bit          BYPASS_EN = 1'b1
) (
  input logic               clock,
  input logic               reset_n,
  register_file_mp_if.slave rf
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] SP_IDX   = ADDR_W'(SP_INDEX);
  localparam logic [XLEN-1:0]   SP_VAL   = XLEN'(SP_INIT);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;

  // Storage has no reset so it can map onto block RAM; the clear sequencer initialises it.
  logic [XLEN-1:0]   regs_q [NUM_REGS];

  logic              run;
  logic              wr0_go;
  logic              wr1_go;
  logic [XLEN-1:0]   rd1_val;
  logic [XLEN-1:0]   rd2_val;

  assign run    = (state_q == ST_RUN);
  assign wr1_go = run && rf.we1 && (rf.addr_rd1 != '0);
  assign wr0_go = run && rf.we0 && (rf.addr_rd0 != '0) &&
                  !(wr1_go && (rf.addr_rd1 == rf.addr_rd0));

  function automatic logic [XLEN-1:0] readPort(
    input logic [ADDR_W-1:0] addr,
    input logic [XLEN-1:0]   arrVal,
    input logic              w0,
    input logic [ADDR_W-1:0] a0,
    input logic [XLEN-1:0]   d0,
    input logic              w1,
    input logic [ADDR_W-1:0] a1,
    input logic [XLEN-1:0]   d1
  );
    logic [XLEN-1:0] val;
    val = arrVal;
    if (addr == '0) begin
      val = '0;
    end else if (BYPASS_EN && w1 && (a1 == addr)) begin
      val = d1;
    end else if (BYPASS_EN && w0 && (a0 == addr)) begin
      val = d0;
    end
    return val;
  endfunction

  always_comb begin
    rd1_val = readPort(rf.addr_rs1, regs_q[rf.addr_rs1], wr0_go, rf.addr_rd0, rf.data_rd0,
                       wr1_go, rf.addr_rd1, rf.data_rd1);
    rd2_val = readPort(rf.addr_rs2, regs_q[rf.addr_rs2], wr0_go, rf.addr_rd0, rf.data_rd0,
                       wr1_go, rf.addr_rd1, rf.data_rd1);
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      rs1_d     = '0;
      rs2_d     = '0;
      if (clr_cnt_q == LAST_IDX) begin
        state_d = ST_RUN;
      end
    end else if (rf.rd_en) begin
      rs1_d = rd1_val;
      rs2_d = rd2_val;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
    end
  end

  // wr0_go already excludes a collision with port 1, so at most one write per entry per edge.
  always_ff @(posedge clock) begin
    if (!run) begin
      regs_q[clr_cnt_q] <= (clr_cnt_q == SP_IDX) ? SP_VAL : '0;
    end else begin
      if (wr0_go) begin
        regs_q[rf.addr_rd0] <= rf.data_rd0;
      end
      if (wr1_go) begin
        regs_q[rf.addr_rd1] <= rf.data_rd1;
      end
    end
  end

  assign rf.data_rs1 = rs1_q;
  assign rf.data_rs2 = rs2_q;
  assign rf.ready    = run;

endmodule
